decode_queue: RTL

- Buffered, parametrised decode stage between fetch and the second decode stage.
- Captures fetched instructions into a DEPTH-entry FIFO using a valid/ready handshake, so a fetch burst is not lost while decode is stalled.
- Decodes the head entry into opcode, register, immediate and illegal fields.
- Immediates are either RV32I sign-extended or zero-extended (legacy mode), selected by parameter.

---
 rtl/decode_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// Instruction queue between fetch and second-stage decode: a DEPTH-entry FIFO
// whose head entry is decoded combinationally into opcode, register, immediate and illegal fields.
module decode_queue #(
  parameter int DEPTH        = 4,
  parameter bit SIGN_EXT_IMM = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     STALL,
  input  logic                     MEM_WAIT,
  input  logic                     INST_VALID,
  output logic                     INST_READY,
  input  logic [31:0]              INST_PC,
  input  logic [31:0]              INST_DATA,
  output logic                     DECODE_VALID,
  output logic [31:0]              DECODE_PC,
  output logic [16:0]              DECODE_OPCODE,
  output logic [4:0]               DECODE_RD,
  output logic [4:0]               DECODE_RS1,
  output logic [4:0]               DECODE_RS2,
  output logic [31:0]              DECODE_IMM,
  output logic                     DECODE_ILLEGAL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        push;
  logic        pop;
  logic [31:0] head_inst;
  logic [31:0] head_pc;

  function automatic logic opcode_known(input logic [6:0] op);
    logic known;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: known = 1'b1;
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

  // The sign bit keeps its place in the immediate; only the upper fill changes with mode.
  function automatic logic [31:0] build_imm(input logic [31:0] inst);
    logic        fill;
    logic [31:0] imm;
    fill = SIGN_EXT_IMM ? inst[31] : 1'b0;
    case (inst[6:0])
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
        imm = {{20{fill}}, inst[31:20]};
      OP_STORE:
        imm = {{20{fill}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{fill}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{11{fill}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_OP:
        imm = 32'h0000_0000;
      default:
        imm = 32'hFFFF_FFFF;
    endcase
    return imm;
  endfunction

  // Ready depends only on occupancy and flush, never on a same-cycle pop.
  assign INST_READY   = (count_q != FULL_CNT) && !FLUSH;
  assign DECODE_VALID = (count_q != '0);
  assign COUNT        = count_q;

  assign push = INST_VALID && INST_READY;
  assign pop  = DECODE_VALID && !STALL && !MEM_WAIT && !FLUSH;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (FLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= 32'h0000_0000;
        data_q[i] <= NOP_INST;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        pc_q[wptr_q]   <= INST_PC;
        data_q[wptr_q] <= INST_DATA;
      end
    end
  end

  // An empty queue presents a NOP at PC 0 so downstream sees benign fields.
  assign head_inst = DECODE_VALID ? data_q[rptr_q] : NOP_INST;
  assign head_pc   = DECODE_VALID ? pc_q[rptr_q]   : 32'h0000_0000;

  assign DECODE_PC      = head_pc;
  assign DECODE_OPCODE  = {head_inst[6:0], head_inst[14:12], head_inst[31:25]};
  assign DECODE_RD      = head_inst[11:7];
  assign DECODE_RS1     = head_inst[19:15];
  assign DECODE_RS2     = head_inst[24:20];
  assign DECODE_IMM     = build_imm(head_inst);
  assign DECODE_ILLEGAL = (head_inst[1:0] != 2'b11) || !opcode_known(head_inst[6:0]);

endmodule
